// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter_pkg
// Brief    : Shared state encodings, log2 helper and default widths.
// Revision : 1.0
// ============================================================================
package mem_port_arbiter_pkg;

   localparam int DEF_BIT_WIDTH = 32;
   localparam int DEF_DEPTH     = 2;
   localparam int DEF_TIMEOUT   = 16;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_t;

   // Ceiling log2, never below 1 so a select of DEPTH=2 still has one bit.
   function automatic int log2(input int value);
      int r;
      r = 1;
      while ((1 << r) < value) r = r + 1;
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter_if
// Brief    : Requester/resource bundle of the shared-port arbiter.
// Revision : 1.0
// ============================================================================
interface mem_port_arbiter_if
   import mem_port_arbiter_pkg::*;
#(
   parameter int BIT_WIDTH = DEF_BIT_WIDTH,
   parameter int DEPTH     = DEF_DEPTH,
   parameter int SEL_WIDTH = log2(DEPTH)
) ();

   logic [DEPTH-1:0]           req;
   logic [BIT_WIDTH*DEPTH-1:0] dataIn;
   logic                       res_done;
   logic [DEPTH-1:0]           gnt;
   logic [SEL_WIDTH-1:0]       sel;
   logic                       res_valid;
   logic [BIT_WIDTH-1:0]       res_data;
   logic [DEPTH-1:0]           ack;
   logic                       timeout_err;

   modport master (
      output req, dataIn, res_done,
      input  gnt, sel, res_valid, res_data, ack, timeout_err
   );

   modport slave (
      input  req, dataIn, res_done,
      output gnt, sel, res_valid, res_data, ack, timeout_err
   );

endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter_mux.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter_mux
// Brief    : Generic DEPTH-to-1 mux over a packed payload vector.
// Revision : 1.0
// ============================================================================
module mem_port_arbiter_mux
   import mem_port_arbiter_pkg::*;
#(
   parameter int BIT_WIDTH = DEF_BIT_WIDTH,
   parameter int DEPTH     = DEF_DEPTH,
   parameter int SEL_WIDTH = log2(DEPTH)
) (
   input  logic [SEL_WIDTH-1:0]       i_sel,
   input  logic [BIT_WIDTH*DEPTH-1:0] i_data,
   output logic [BIT_WIDTH-1:0]       o_data
);

   logic [BIT_WIDTH-1:0] w_slice [DEPTH];

   generate
      for (genvar g = 0; g < DEPTH; g++) begin : g_slice
         assign w_slice[g] = i_data[BIT_WIDTH*g +: BIT_WIDTH];
      end
   endgenerate

   // Select codes at or above DEPTH yield zero.
   always_comb begin
      o_data = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (i_sel == SEL_WIDTH'(i)) o_data = w_slice[i];
      end
   end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Round-robin owner of a single-ported resource with watchdog.
// Revision : 1.0
// ============================================================================
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int BIT_WIDTH = DEF_BIT_WIDTH,
   parameter int DEPTH     = DEF_DEPTH,
   parameter int SEL_WIDTH = log2(DEPTH),
   parameter int TIMEOUT   = DEF_TIMEOUT
) (
   input logic               clk,
   input logic               rst_n,
   mem_port_arbiter_if.slave bus
);

   localparam int                   WD_WIDTH  = log2(TIMEOUT);
   localparam logic [WD_WIDTH-1:0]  c_wd_last = WD_WIDTH'(TIMEOUT - 1);
   localparam logic [DEPTH-1:0]     c_one     = DEPTH'(1);

   arb_state_t             r_state;
   logic [SEL_WIDTH-1:0]   r_ptr;
   logic [SEL_WIDTH-1:0]   r_sel;
   logic [WD_WIDTH-1:0]    r_wd_cnt;
   logic [DEPTH-1:0]       r_gnt;
   logic                   r_res_valid;
   logic                   r_timeout_err;

   logic                   w_done;
   logic                   w_timeout;
   logic [SEL_WIDTH-1:0]   w_next_ptr;
   logic [SEL_WIDTH-1:0]   w_start;
   logic [DEPTH-1:0]       w_req_m;
   logic [2*DEPTH-1:0]     w_req2;
   logic                   w_found;
   logic [SEL_WIDTH-1:0]   w_pick;
   logic [DEPTH-1:0]       w_pick_oh;
   logic [BIT_WIDTH-1:0]   w_mux_out;

   assign w_done     = bus.res_done & r_res_valid;
   assign w_timeout  = (r_state == BUSY) && (r_wd_cnt == c_wd_last) && !w_done;
   assign w_next_ptr = (r_sel == SEL_WIDTH'(DEPTH - 1)) ? '0 : r_sel + SEL_WIDTH'(1);

   // While busy the search only matters on completion, so it always starts
   // past the current owner and never re-selects it.
   assign w_start = (r_state == BUSY) ? w_next_ptr : r_ptr;
   assign w_req_m = (r_state == BUSY) ? (bus.req & ~r_gnt) : bus.req;
   assign w_req2  = {w_req_m, w_req_m};

   // Descending scan: the last hit kept is the lowest doubled index >= start.
   always_comb begin
      w_found = 1'b0;
      w_pick  = '0;
      for (int j = 2*DEPTH - 1; j >= 0; j--) begin
         if (w_req2[j] && (j >= int'(w_start))) begin
            w_found = 1'b1;
            w_pick  = SEL_WIDTH'((j >= DEPTH) ? (j - DEPTH) : j);
         end
      end
   end

   assign w_pick_oh = c_one << w_pick;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state       <= IDLE;
         r_ptr         <= '0;
         r_sel         <= '0;
         r_wd_cnt      <= '0;
         r_gnt         <= '0;
         r_res_valid   <= 1'b0;
         r_timeout_err <= 1'b0;
      end else begin
         r_timeout_err <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_found) begin
                  r_state     <= BUSY;
                  r_sel       <= w_pick;
                  r_gnt       <= w_pick_oh;
                  r_res_valid <= 1'b1;
                  r_wd_cnt    <= '0;
               end
            end
            BUSY: begin
               if (w_done) begin
                  r_ptr    <= w_next_ptr;
                  r_wd_cnt <= '0;
                  if (w_found) begin
                     r_sel <= w_pick;
                     r_gnt <= w_pick_oh;
                  end else begin
                     r_state     <= IDLE;
                     r_gnt       <= '0;
                     r_res_valid <= 1'b0;
                  end
               end else if (w_timeout) begin
                  r_ptr         <= w_next_ptr;
                  r_timeout_err <= 1'b1;
                  r_state       <= IDLE;
                  r_gnt         <= '0;
                  r_res_valid   <= 1'b0;
                  r_wd_cnt      <= '0;
               end else begin
                  r_wd_cnt <= r_wd_cnt + WD_WIDTH'(1);
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   mem_port_arbiter_mux #(
      .BIT_WIDTH (BIT_WIDTH),
      .DEPTH     (DEPTH)
   ) u_mux (
      .i_sel  (r_sel),
      .i_data (bus.dataIn),
      .o_data (w_mux_out)
   );

   assign bus.gnt         = r_gnt;
   assign bus.sel         = r_sel;
   assign bus.res_valid   = r_res_valid;
   assign bus.timeout_err = r_timeout_err;
   assign bus.ack         = r_gnt & {DEPTH{w_done}};
   assign bus.res_data    = r_res_valid ? w_mux_out : '0;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Brief    : Scoreboard bench for mem_port_arbiter (DEPTH=3, 8-bit, TIMEOUT=8).
// Revision : 1.0
// ============================================================================
module tb_mem_port_arbiter;

   localparam int BW  = 8;
   localparam int N   = 3;
   localparam int SW  = 2;
   localparam int TO  = 8;

   typedef struct {
      logic [N-1:0]  gnt;
      logic [SW-1:0] sel;
      logic          valid;
      logic [BW-1:0] data;
      logic [N-1:0]  ack;
      logic          terr;
   } exp_t;

   logic clk;
   logic rst_n;

   mem_port_arbiter_if #(.BIT_WIDTH(BW), .DEPTH(N), .SEL_WIDTH(SW)) bus ();

   mem_port_arbiter #(
      .BIT_WIDTH (BW),
      .DEPTH     (N),
      .SEL_WIDTH (SW),
      .TIMEOUT   (TO)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   exp_t    q[$];
   int      checks   = 0;
   int      failures = 0;
   int      cyc      = 0;
   logic [BW-1:0] pay [N] = '{8'hA0, 8'hB1, 8'hC2};

   bit           to_seen  = 0;
   int           to_index = -1;
   logic [N-1:0] to_gnt   = '1;

   // Reference model: who owns the resource, where the search starts, how
   // long the current owner has held it, and a pending timeout pulse.
   int owner = -1;
   int ptr   = 0;
   int age   = 0;
   bit terr  = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic int pick(input logic [N-1:0] r, input int start, input int excl);
      for (int k = 0; k < N; k++) begin
         int j;
         j = (start + k) % N;
         if (r[j] && j != excl) return j;
      end
      return -1;
   endfunction

   task automatic expect_now(input bit cond, input string what);
      checks++;
      if (!cond) begin
         failures++;
         $display("FAIL cycle%0d: %s", cyc, what);
      end
   endtask

   task automatic step(input logic [N-1:0] r, input logic d, input logic rn);
      exp_t e;
      @(negedge clk);
      bus.req      = r;
      bus.res_done = d;
      rst_n        = rn;
      cyc++;
      e.valid = (owner >= 0);
      e.gnt   = e.valid ? N'(1 << owner) : '0;
      e.sel   = e.valid ? SW'(owner) : '0;
      e.data  = e.valid ? pay[owner] : '0;
      e.ack   = (e.valid && d) ? e.gnt : '0;
      e.terr  = terr;
      q.push_back(e);
      terr = 0;
      if (!rn) begin
         owner = -1; ptr = 0; age = 0;
      end else if (owner < 0) begin
         owner = pick(r, ptr, -1);
         age   = 0;
      end else if (d) begin
         int done_idx;
         done_idx = owner;
         ptr   = (owner + 1) % N;
         owner = pick(r, ptr, done_idx);
         age   = 0;
      end else if (age == TO - 1) begin
         terr  = 1;
         ptr   = (owner + 1) % N;
         owner = -1;
         age   = 0;
      end else begin
         age++;
      end
   endtask

   // Monitor: compares every presented cycle against the queued expectation.
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (q.size() != 0) begin
            exp_t e;
            logic ok;
            e  = q.pop_front();
            ok = (bus.gnt === e.gnt) && (bus.res_valid === e.valid) &&
                 (bus.res_data === e.data) && (bus.ack === e.ack) &&
                 (bus.timeout_err === e.terr) && (!e.valid || bus.sel === e.sel);
            checks++;
            if (!ok) begin
               failures++;
               $display("FAIL cycle%0d: got gnt=%b sel=%0d valid=%b data=%h ack=%b terr=%b, expected gnt=%b sel=%0d valid=%b data=%h ack=%b terr=%b",
                        cyc, bus.gnt, bus.sel, bus.res_valid, bus.res_data, bus.ack, bus.timeout_err,
                        e.gnt, e.sel, e.valid, e.data, e.ack, e.terr);
            end
         end
      end
   end

   initial begin
      rst_n        = 1'b0;
      bus.req      = 3'b111;
      bus.res_done = 1'b0;
      bus.dataIn   = {8'hC2, 8'hB1, 8'hA0};
      repeat (2) @(posedge clk);

      // Reset with all requests held, then the first grant.
      step(3'b111, 0, 0);
      step(3'b111, 0, 1);
      #1;
      expect_now((bus.gnt === '0) && (bus.res_valid === 1'b0) && (bus.res_data === '0) &&
                 (bus.ack === '0) && (bus.timeout_err === 1'b0),
                 "outputs not zero in reset state");
      step(3'b111, 0, 1);
      // Back-to-back rotation 0,1,2,0 with completion every second cycle.
      step(3'b111, 1, 1);
      step(3'b111, 0, 1);
      step(3'b111, 1, 1);
      step(3'b111, 0, 1);
      step(3'b111, 1, 1);
      step(3'b111, 0, 1);
      step(3'b111, 1, 1);
      step(3'b010, 1, 1);
      // Lone requester 2 with a one-cycle transaction, wrap of the pointer.
      step(3'b100, 0, 1);
      step(3'b100, 1, 1);
      step(3'b000, 0, 1);
      // Watchdog on requester 1, then re-arbitration from the wrapped pointer.
      step(3'b010, 0, 1);
      for (int i = 0; i < TO + 1; i++) begin
         step(3'b011, 0, 1);
         #1;
         if (bus.timeout_err === 1'b1 && !to_seen) begin
            to_seen  = 1;
            to_index = i;
            to_gnt   = bus.gnt;
         end
      end
      expect_now(to_seen && (to_index == TO) && (to_gnt === '0),
                 "expired wait did not pulse timeout_err with gnt dropped");
      step(3'b011, 0, 1);
      step(3'b011, 1, 1);
      step(3'b000, 1, 1);
      // Request dropped mid-grant keeps the grant until completion.
      step(3'b001, 0, 1);
      for (int i = 0; i < 3; i++) step(3'b000, 0, 1);
      step(3'b000, 1, 1);
      // Reset mid-grant; pointer returns to 0.
      step(3'b001, 0, 1);
      step(3'b001, 0, 1);
      step(3'b001, 0, 0);
      step(3'b011, 0, 1);
      // Completion on the exact cycle the watchdog would fire.
      for (int i = 0; i < TO - 1; i++) step(3'b011, 0, 1);
      step(3'b011, 1, 1);
      step(3'b011, 0, 1);
      step(3'b000, 1, 1);
      step(3'b000, 0, 1);

      // Randomized traffic: alternating busy and stall-heavy completion rates.
      for (int c = 0; c < 1500; c++) begin
         logic [N-1:0] r;
         logic d;
         logic rn;
         r  = N'($urandom_range(0, 7));
         d  = ((c % 400) < 200) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 15) == 0);
         rn = ($urandom_range(0, 255) != 0);
         step(r, d, rn);
      end

      #5;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Round-robin arbiter that shares one single-ported resource among `DEPTH` requesters, such as the unified memory port contended by the IF and MEM stages or a shared multi-cycle unit. Each requester presents a request and a packed payload. The block grants one requester at a time and holds the grant until the resource signals completion. Its registered select drives an internal generic mux, which forwards the winner's payload to the resource. A watchdog releases the resource if completion never arrives.

## Interface
Parameters:
- `BIT_WIDTH`, 32: payload width per requester.
- `DEPTH`, 2: number of requesters; minimum 2, need not be a power of two.
- `SEL_WIDTH`, log2(DEPTH): width of the select/index.
- `TIMEOUT`, 16: maximum cycles a grant may be held without `res_done`; minimum 2.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `req`  in  DEPTH  request per requester; bit i = requester i.
- `dataIn`  in  BIT_WIDTH*DEPTH  packed payloads; requester i occupies bits [BIT_WIDTH*i +: BIT_WIDTH].
- `res_done`  in  1  resource completion; valid only while `res_valid`=1.
- `gnt`  out  DEPTH  one-hot grant, registered.
- `sel`  out  SEL_WIDTH  index of the granted requester, registered.
- `res_valid`  out  1  the resource is granted and the payload is valid.
- `res_data`  out  BIT_WIDTH  the granted payload; forced to 0 when `res_valid`=0.
- `ack`  out  DEPTH  combinational: `gnt & {DEPTH{res_done & res_valid}}`.
- `timeout_err`  out  1  one-cycle pulse when the watchdog aborts a grant.

## Operation
- States: IDLE and BUSY, encoded as 1 bit. Internal registers are `ptr` (the priority start index, 0..DEPTH-1) and `wd_cnt` (the watchdog counter).
- Arbitration: scan indices `ptr`, `ptr+1`, … modulo DEPTH, wrapping at DEPTH (not at 2^SEL_WIDTH). The first index with `req` set wins.
- IDLE:
  - If any `req` is set, register the winner into `sel`/`gnt`, set `res_valid`=1, clear `wd_cnt`, and go to BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - `gnt`, `sel` and `res_valid` hold steady. `wd_cnt` increments each cycle.
  - On `res_done`=1, set `ptr` = (`sel`+1) mod DEPTH. Then arbitrate the current `req` using that new `ptr`, excluding the just-completed index for this one decision.
    - If there is a winner, grant it next cycle and stay in BUSY. There are zero dead cycles between grants.
    - If there is no winner, clear `gnt` and `res_valid` and go to IDLE.
  - If `wd_cnt` reaches TIMEOUT-1 and `res_done`=0, pulse `timeout_err`, update `ptr` the same way as on completion, clear the grant, and go to IDLE. No `ack` is issued.
- Requester protocol: `req[i]` must stay high until `ack[i]`.
  - Deasserting `req[i]` while granted does not release the grant. Only `res_done` or the watchdog releases it.
- `res_done` while `res_valid`=0 is ignored.
- Reset overrides everything, including mid-grant. After reset: state IDLE; `gnt`=0, `sel`=0, `ptr`=0, `res_valid`=0, `wd_cnt`=0, `timeout_err`=0. `res_data`=0 and `ack`=0 follow from the gating.

## Timing
- `req` sampled in cycle N → `gnt`/`sel`/`res_valid` asserted from cycle N+1.
- `res_data` is combinational from `dataIn` through the mux, using the registered `sel`. There is no extra latency, and payload changes propagate within the cycle.
- `res_done` in cycle M:
  - `ack` is high in cycle M.
  - The next grant, or release, is visible at M+1.
  - `res_done` on the first granted cycle is legal, giving a 1-cycle transaction.
- Watchdog: the grant starts at cycle G. `timeout_err` is high in cycle G+TIMEOUT and the grant is dropped in that same cycle. If `res_done` arrives in the same cycle the timeout would fire, completion wins and no error is raised.

## Structure
- The shared defines header holds:
  - the state encodings IDLE/BUSY;
  - the common `log2` constant function, also used by the generic mux;
  - default widths.
- Instantiate the codebase's generic mux as the one sub-module: `BIT_WIDTH`/`DEPTH` are passed through, `sel` is the registered select, and its output is gated by `res_valid`.
- The round-robin search is a combinational function or for-loop over a doubled request vector.
- Expected size: about 150–200 lines of RTL.

## Test plan
Bench configuration: DEPTH=3, BIT_WIDTH=8, TIMEOUT=8; payloads 0xA0, 0xB1, 0xC2 for requesters 0, 1, 2.
- Reset with `req`=3'b111 held → all outputs 0. First rising edge after `rst_n`=1 → `gnt`=001, `res_data`=0xA0.
- `req`=111 held, `res_done` pulsed every 2nd granted cycle → grant order 0, 1, 2, 0, with no idle cycle between grants. `ack` pulses 001, 010, 100.
- Only `req`=100; `res_done` on the first granted cycle → `gnt`=100 for exactly one cycle, `ack`=100, then IDLE with `res_data`=0. After the wrap, `ptr`=0.
- Grant requester 1, `res_done` held 0 → `timeout_err` pulses 8 cycles after the grant and `gnt` goes to 0. With `req`=011 still set, the next grant goes to 0 (`ptr`=2 wraps past 2 to 0).
- Grant requester 0, then drop `req[0]` mid-grant → `gnt` stays 001 until `res_done`. Assert `rst_n`=0 mid-grant → the next cycle `gnt`=0, `res_valid`=0, `ptr`=0.
- Fire `res_done` and the timeout in the same cycle → `ack` is asserted and `timeout_err` stays 0.
